// File: rtl/inv_sub_nibbles_serial.sv
// Serial SSAES InvSubNibbles: one nibble per cycle through inverse affine + GF(2^4) inversion.
// Optional register stage (PIPE=1) between the affine map and the field inversion.
module inv_sub_nibbles_serial #(
    parameter int PIPE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_state,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_state,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [63:0] work;
    logic [3:0]  cnt;
    logic [3:0]  preg;
    logic        pv;
    logic        tail;
    logic        ov;
    logic        rdy;

    logic        accept;
    logic        run_en;
    logic        rd_en;
    logic        wr_en;
    logic        last;
    logic [3:0]  rd_nib;
    logic [3:0]  aff;
    logic [3:0]  wr_idx;
    logic [3:0]  wr_nib;

    // Field arithmetic in GF(2^4) with modulus x^4 + x + 1.
    function automatic logic [3:0] xt(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        return ({4{b[0]}} & a) ^ ({4{b[1]}} & xt(a)) ^
               ({4{b[2]}} & xt(xt(a))) ^ ({4{b[3]}} & xt(xt(xt(a))));
    endfunction

    // a^14 = a^-1 for nonzero a; 0 maps to 0 naturally.
    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf_mul(a, a);
        a4 = gf_mul(a2, a2);
        a8 = gf_mul(a4, a4);
        return gf_mul(gf_mul(a2, a4), a8);
    endfunction

    // Undo the forward affine step: remove constant 6, then apply the inverse linear map.
    function automatic logic [3:0] inv_affine(input logic [3:0] y);
        logic [3:0] z;
        z = y ^ 4'h6;
        return {z[1] ^ z[2] ^ z[3],
                z[0] ^ z[1] ^ z[2],
                z[0] ^ z[1] ^ z[3],
                z[0] ^ z[2] ^ z[3]};
    endfunction

    assign in_ready  = (state == IDLE) && rdy;
    assign busy      = (state == RUN);
    assign out_valid = ov;
    assign out_state = work;

    assign accept = in_valid && in_ready && !clr;
    assign run_en = (state == RUN) && !clr;
    assign rd_nib = work[{cnt, 2'b00} +: 4];
    assign aff    = inv_affine(rd_nib);

    // With the pipe stage, the write trails the read by one cycle and the
    // tail flag adds the seventeenth cycle that drains nibble 15.
    always_comb begin
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        last   = 1'b0;
        wr_idx = cnt;
        wr_nib = gf_inv(aff);
        if (PIPE != 0) begin
            rd_en  = run_en && !tail;
            wr_en  = run_en && pv;
            last   = tail && pv;
            wr_idx = cnt - 4'd1;
            wr_nib = gf_inv(preg);
        end else begin
            rd_en  = run_en;
            wr_en  = run_en;
            last   = (cnt == 4'd15);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (run_en && last) state_nx = DONE;
            DONE:    if (ov && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clr) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            preg  <= '0;
            pv    <= 1'b0;
            tail  <= 1'b0;
            ov    <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            state <= state_nx;
            rdy   <= 1'b1;
            // Valid rises one edge after DONE is entered and drops on handshake or abort.
            ov    <= (state == DONE) && (state_nx == DONE);
            if (accept) begin
                work <= in_state;
                cnt  <= '0;
                pv   <= 1'b0;
                tail <= 1'b0;
            end else begin
                if (rd_en) begin
                    cnt  <= cnt + 4'd1;
                    preg <= aff;
                    pv   <= 1'b1;
                    if (cnt == 4'd15) tail <= 1'b1;
                end
                if (wr_en) work[{wr_idx, 2'b00} +: 4] <= wr_nib;
            end
        end
    end

endmodule
